mod_counter_sequencer: RTL

- Command sequencer directly upstream of the 8-bit MOD counter.
- Accepts a run request (preload, modulus, rollover target) and drives the counter's Load/Start/Stop command pulses, Enable, preload and MOD value.
- Counts the counter's rollover flags and stops the counter after the requested number of wraps, or on abort.
- Reports ready/done/error status to the controlling logic.

---
 rtl/mod_counter_pkg.sv | 19 +
 rtl/mod_counter_sequencer_handshake_timer.sv | 32 +++
 rtl/mod_counter_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the MOD counter sequencer.
// Holds the sequencer state enum and default sizing constants.
package mod_counter_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int HS_TIMEOUT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_RUN,
    RUN,
    STOP,
    WAIT_HALT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mod_counter_sequencer_handshake_timer.sv
// Handshake down-counter: loaded on wait-state entry, flags expiry.
// Ports: clk, rst_n, load (reload pulse), expired (count reached 0).
module handshake_timer
  import mod_counter_pkg::*;
#(
  parameter int TIMEOUT = HS_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // Loaded with TIMEOUT-1 so expiry is seen in the
  // TIMEOUT-th cycle of the wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mod_counter_sequencer.sv
// Command sequencer driving the MOD counter through load/start/stop.
// Ports: run request/abort in, counter flags in, commands/status out.
module mod_counter_sequencer
  import mod_counter_pkg::*;
#(
  parameter int WIDTH             = WIDTH_DEF,
  parameter int HANDSHAKE_TIMEOUT = HS_TIMEOUT_DEF
) (
  input  logic             Clk_In,
  input  logic             Reset_n_In,
  input  logic             Run_Request_In,
  input  logic             Abort_In,
  input  logic [WIDTH-1:0] Preload_Value_In,
  input  logic [WIDTH-1:0] MOD_Value_In,
  input  logic [WIDTH-1:0] Rollover_Target_In,
  input  logic             Counter_Running_Flag_In,
  input  logic             Counter_Rollover_Flag_In,
  output logic             Enable_Out,
  output logic             Start_Counter_Command_Out,
  output logic             Stop_Counter_Command_Out,
  output logic             Load_Counter_Value_Command_Out,
  output logic [WIDTH-1:0] Preload_Counter_Value_Out,
  output logic [WIDTH-1:0] MOD_Value_Out,
  output logic             Ready_Out,
  output logic             Done_Out,
  output logic             Error_Out,
  output logic [WIDTH-1:0] Rollover_Count_Out
);

  seq_state_t       state_q, state_d;
  logic             en_q;
  logic             err_q, err_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             accept;
  logic             tmr_load;
  logic             tmr_expired;

  handshake_timer #(
    .TIMEOUT (HANDSHAKE_TIMEOUT)
  ) u_timer (
    .clk     (Clk_In),
    .rst_n   (Reset_n_In),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  // START and STOP are the only ways into the two wait states.
  assign tmr_load = (state_q == START) || (state_q == STOP);

  assign Ready_Out = (state_q == IDLE) && en_q;
  assign accept    = Run_Request_In && Ready_Out && !Abort_In;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge Clk_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pre_q   <= '0;
      mod_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      mod_q   <= mod_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    mod_d   = mod_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (MOD_Value_In != '0) begin
            pre_d   = Preload_Value_In;
            mod_d   = MOD_Value_In;
            tgt_d   = Rollover_Target_In;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD:  state_d = Abort_In ? STOP : START;
      START: state_d = Abort_In ? STOP : WAIT_RUN;
      WAIT_RUN: begin
        if (Abort_In) begin
          state_d = STOP;
        end else if (Counter_Running_Flag_In) begin
          state_d = RUN;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = STOP;
        end
      end
      RUN: begin
        if (Counter_Rollover_Flag_In) begin
          cnt_d = cnt_inc;
          if (tgt_q != '0 && cnt_inc == tgt_q) begin
            state_d = STOP;
          end
        end
        if (Abort_In) begin
          state_d = STOP;
        end
      end
      STOP: state_d = WAIT_HALT;
      WAIT_HALT: begin
        if (!Counter_Running_Flag_In) begin
          state_d = DONE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Enable_Out                     = en_q;
  assign Load_Counter_Value_Command_Out = (state_q == LOAD);
  assign Start_Counter_Command_Out      = (state_q == START);
  assign Stop_Counter_Command_Out       = (state_q == STOP);
  assign Done_Out                       = (state_q == DONE);
  assign Error_Out                      = err_q;
  assign Rollover_Count_Out             = cnt_q;
  assign Preload_Counter_Value_Out      = pre_q;
  assign MOD_Value_Out                  = mod_q;

endmodule
